// File: rtl/pmod_sf3_driver.sv
// SPI master for the Pmod SF3 (N25Q NOR flash): one start pulse runs one cs_n-framed
// transaction of opcode, optional 24-bit address and optional data bytes (SPI mode 0).
module pmod_sf3_driver #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_cmd,
   input  logic [23:0] i_addr,
   input  logic [7:0]  i_data_in,
   input  logic [7:0]  i_data_len,
   input  logic        i_miso,
   output logic        o_mosi,
   output logic        o_sck,
   output logic        o_cs_n,
   output logic [7:0]  o_data_out,
   output logic        o_done
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

   typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StHold} state_e;

   state_e          r_state, w_state_nxt;
   logic [DivW-1:0] r_div, w_div_nxt;
   logic            r_sck, w_sck_nxt;
   logic            r_cs_n, w_cs_n_nxt;
   logic            r_mosi, w_mosi_nxt;
   logic            r_done, w_done_nxt;
   logic [7:0]      r_tx_shift, w_tx_shift_nxt;
   logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]      r_byte_cnt, w_byte_cnt_nxt;
   logic [7:0]      r_cmd, w_cmd_nxt;
   logic [23:0]     r_addr, w_addr_nxt;
   logic [7:0]      r_len, w_len_nxt;
   logic [7:0]      r_rx_shift, w_rx_shift_nxt;
   logic [7:0]      r_data_out, w_data_out_nxt;

   logic            w_has_addr;
   logic            w_is_wr;
   logic            w_is_rd;
   logic            w_has_data;
   logic            w_half_end;
   logic            w_load;
   logic [7:0]      w_load_byte;
   logic [7:0]      w_data_byte;

   always_comb begin
      w_has_addr = 1'b0;
      w_is_wr    = 1'b0;
      w_is_rd    = 1'b0;
      case (r_cmd)
         8'h02: begin
            w_has_addr = 1'b1;
            w_is_wr    = 1'b1;
         end
         8'h03: begin
            w_has_addr = 1'b1;
            w_is_rd    = 1'b1;
         end
         8'h20, 8'hD8: w_has_addr = 1'b1;
         8'h05, 8'h9F: w_is_rd    = 1'b1;
         default: ;
      endcase
   end

   assign w_has_data  = (w_is_wr || w_is_rd) && (r_len != 8'd0);
   assign w_half_end  = (r_div == DivMax);
   // Read bytes shift out zeros; write bytes take whatever data_in holds at byte start.
   assign w_data_byte = w_is_wr ? i_data_in : 8'h00;

   always_comb begin
      w_state_nxt    = r_state;
      w_div_nxt      = r_div;
      w_sck_nxt      = r_sck;
      w_cs_n_nxt     = r_cs_n;
      w_mosi_nxt     = r_mosi;
      w_done_nxt     = 1'b0;
      w_tx_shift_nxt = r_tx_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_byte_cnt_nxt = r_byte_cnt;
      w_cmd_nxt      = r_cmd;
      w_addr_nxt     = r_addr;
      w_len_nxt      = r_len;
      w_rx_shift_nxt = r_rx_shift;
      w_data_out_nxt = r_data_out;
      w_load         = 1'b0;
      w_load_byte    = 8'h00;

      case (r_state)
         StIdle: begin
            w_sck_nxt  = 1'b0;
            w_cs_n_nxt = 1'b1;
            if (i_start) begin
               w_state_nxt = StCmd;
               w_cs_n_nxt  = 1'b0;
               w_div_nxt   = '0;
               w_cmd_nxt   = i_cmd;
               w_addr_nxt  = i_addr;
               w_len_nxt   = i_data_len;
               w_load      = 1'b1;
               w_load_byte = i_cmd;
            end
         end

         StCmd, StAddr, StData: begin
            if (!w_half_end) begin
               w_div_nxt = r_div + DivW'(1);
            end else begin
               w_div_nxt = '0;
               if (!r_sck) begin
                  w_sck_nxt = 1'b1;
                  if (r_state == StData && w_is_rd) begin
                     w_rx_shift_nxt = {r_rx_shift[6:0], i_miso};
                     if (r_bit_cnt == 3'd0) begin
                        w_data_out_nxt = {r_rx_shift[6:0], i_miso};
                     end
                  end
               end else begin
                  w_sck_nxt = 1'b0;
                  if (r_bit_cnt != 3'd0) begin
                     w_mosi_nxt     = r_tx_shift[7];
                     w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
                     w_bit_cnt_nxt  = r_bit_cnt - 3'd1;
                  end else if (r_state == StCmd && w_has_addr) begin
                     w_state_nxt    = StAddr;
                     w_byte_cnt_nxt = 8'd2;
                     w_load         = 1'b1;
                     w_load_byte    = r_addr[23:16];
                     w_addr_nxt     = {r_addr[15:0], 8'h00};
                  end else if (r_state == StAddr && r_byte_cnt != 8'd0) begin
                     w_byte_cnt_nxt = r_byte_cnt - 8'd1;
                     w_load         = 1'b1;
                     w_load_byte    = r_addr[23:16];
                     w_addr_nxt     = {r_addr[15:0], 8'h00};
                  end else if (r_state != StData && w_has_data) begin
                     w_state_nxt    = StData;
                     w_byte_cnt_nxt = r_len - 8'd1;
                     w_load         = 1'b1;
                     w_load_byte    = w_data_byte;
                  end else if (r_state == StData && r_byte_cnt != 8'd0) begin
                     w_byte_cnt_nxt = r_byte_cnt - 8'd1;
                     w_load         = 1'b1;
                     w_load_byte    = w_data_byte;
                  end else begin
                     w_state_nxt = StHold;
                  end
               end
            end
         end

         StHold: begin
            if (w_half_end) begin
               w_state_nxt = StIdle;
               w_div_nxt   = '0;
               w_cs_n_nxt  = 1'b1;
               w_done_nxt  = 1'b1;
               w_mosi_nxt  = 1'b0;
            end else begin
               w_div_nxt = r_div + DivW'(1);
            end
         end

         default: begin
            w_state_nxt = StIdle;
            w_cs_n_nxt  = 1'b1;
            w_sck_nxt   = 1'b0;
            w_mosi_nxt  = 1'b0;
         end
      endcase

      // First bit goes straight onto mosi; the rest wait in the shifter.
      if (w_load) begin
         w_mosi_nxt     = w_load_byte[7];
         w_tx_shift_nxt = {w_load_byte[6:0], 1'b0};
         w_bit_cnt_nxt  = 3'd7;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_div      <= '0;
         r_sck      <= 1'b0;
         r_cs_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_done     <= 1'b0;
         r_tx_shift <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= 8'd0;
         r_cmd      <= 8'h00;
         r_addr     <= 24'h000000;
         r_len      <= 8'd0;
         r_rx_shift <= 8'h00;
         r_data_out <= 8'h00;
      end else begin
         r_state    <= w_state_nxt;
         r_div      <= w_div_nxt;
         r_sck      <= w_sck_nxt;
         r_cs_n     <= w_cs_n_nxt;
         r_mosi     <= w_mosi_nxt;
         r_done     <= w_done_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_cmd      <= w_cmd_nxt;
         r_addr     <= w_addr_nxt;
         r_len      <= w_len_nxt;
         r_rx_shift <= w_rx_shift_nxt;
         r_data_out <= w_data_out_nxt;
      end
   end

   assign o_mosi     = r_mosi;
   assign o_sck      = r_sck;
   assign o_cs_n     = r_cs_n;
   assign o_data_out = r_data_out;
   assign o_done     = r_done;

endmodule

// File: tb/tb_pmod_sf3_driver.sv
// Directed bench for pmod_sf3_driver: a posedge+1 monitor logs sck rises, mosi bits,
// cs_n-low cycles and done pulses, and plays back miso bits; transactions are checked by delta.
`timescale 1ns/1ps
module tb_pmod_sf3_driver;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        start    = 1'b0;
   logic [7:0]  cmd      = 8'h00;
   logic [23:0] addr     = 24'h000000;
   logic [7:0]  data_in  = 8'h00;
   logic [7:0]  data_len = 8'h00;
   logic        miso     = 1'b0;
   logic        mosi;
   logic        sck;
   logic        cs_n;
   logic [7:0]  data_out;
   logic        done;

   always #5 clk = ~clk;

   pmod_sf3_driver #(.CLK_DIV(2)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_cmd      (cmd),
      .i_addr     (addr),
      .i_data_in  (data_in),
      .i_data_len (data_len),
      .i_miso     (miso),
      .o_mosi     (mosi),
      .o_sck      (sck),
      .o_cs_n     (cs_n),
      .o_data_out (data_out),
      .o_done     (done)
   );

   int   n_checks  = 0;
   int   n_fail    = 0;
   int   rise_cnt  = 0;
   int   low_cnt   = 0;
   int   done_cnt  = 0;
   int   sck_bad   = 0;
   int   miso_base = 0;
   logic sck_prev  = 1'b0;
   logic mosi_log  [0:4095];
   logic miso_bits [0:63];

   always @(posedge clk) begin
      int idx;
      #1;
      if (cs_n === 1'b0) low_cnt++;
      if (done === 1'b1) done_cnt++;
      if (sck === 1'b1 && cs_n === 1'b1) sck_bad++;
      if (sck === 1'b1 && sck_prev === 1'b0) begin
         mosi_log[rise_cnt % 4096] = mosi;
         rise_cnt++;
      end
      sck_prev = sck;
      idx = rise_cnt - miso_base;
      miso = (idx >= 0 && idx < 64) ? miso_bits[idx] : 1'b0;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input logic [7:0] t_cmd, input logic [23:0] t_addr,
                          input logic [7:0] t_din, input logic [7:0] t_len,
                          input int probe_at, input int glitch_at, input int reset_at,
                          output int rises, output logic [63:0] stream, output int lows,
                          output int dones, output logic [7:0] probe_val,
                          output logic timed_out);
      int b_rise;
      int b_low;
      int b_done;
      int d;
      bit probed;
      bit glitched;
      bit aborted;
      b_rise    = rise_cnt;
      b_low     = low_cnt;
      b_done    = done_cnt;
      miso_base = rise_cnt;
      probed    = 1'b0;
      glitched  = 1'b0;
      aborted   = 1'b0;
      timed_out = 1'b1;
      probe_val = 8'h00;
      @(negedge clk);
      cmd      = t_cmd;
      addr     = t_addr;
      data_in  = t_din;
      data_len = t_len;
      start    = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         cmd   = t_cmd;
         d     = rise_cnt - b_rise;
         if (done_cnt != b_done) begin
            timed_out = 1'b0;
            break;
         end
         if (probe_at >= 0 && !probed && d >= probe_at) begin
            probe_val = data_out;
            probed    = 1'b1;
         end
         if (glitch_at >= 0 && !glitched && d >= glitch_at) begin
            start    = 1'b1;
            cmd      = 8'h06;
            glitched = 1'b1;
         end
         if (reset_at >= 0 && d >= reset_at) begin
            reset     = 1'b1;
            aborted   = 1'b1;
            timed_out = 1'b0;
            break;
         end
      end
      if (!aborted) repeat (3) @(negedge clk);
      rises  = rise_cnt - b_rise;
      lows   = low_cnt - b_low;
      dones  = done_cnt - b_done;
      stream = 64'h0;
      for (int i = 0; i < rises && i < 64; i++) begin
         stream = {stream[62:0], mosi_log[(b_rise + i) % 4096]};
      end
   endtask

   initial begin
      logic [63:0] st;
      logic [7:0]  pv;
      logic        to;
      int          r;
      int          l;
      int          dn;
      int          dbase;

      for (int i = 0; i < 64; i++) miso_bits[i] = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_data_out", data_out, 8'h00);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // WREN with data_len=1: opcode only
      run_txn(8'h06, 24'h000000, 8'hA5, 8'd1, -1, -1, -1, r, st, l, dn, pv, to);
      check("wren_timeout", to, 1'b0);
      check("wren_rises", r, 8);
      check("wren_mosi", st, 64'h06);
      check("wren_cs_low", l, 34);
      check("wren_done", dn, 1);

      // RDSR, two status bytes 0x03 then 0x00; address must not be sent
      miso_bits[14] = 1'b1;
      miso_bits[15] = 1'b1;
      run_txn(8'h05, 24'hABCDEF, 8'h00, 8'd2, 20, -1, -1, r, st, l, dn, pv, to);
      check("rdsr_timeout", to, 1'b0);
      check("rdsr_rises", r, 24);
      check("rdsr_mosi", st, 64'h050000);
      check("rdsr_byte1", pv, 8'h03);
      check("rdsr_data_out", data_out, 8'h00);
      check("rdsr_cs_low", l, 98);
      check("rdsr_done", dn, 1);

      // Read one byte with miso held high
      for (int i = 0; i < 64; i++) miso_bits[i] = 1'b1;
      run_txn(8'h03, 24'h000001, 8'h00, 8'd1, -1, -1, -1, r, st, l, dn, pv, to);
      check("read_timeout", to, 1'b0);
      check("read_rises", r, 40);
      check("read_mosi", st, 64'h0300000100);
      check("read_data_out", data_out, 8'hFF);
      check("read_cs_low", l, 162);
      check("read_done", dn, 1);

      // Page program leaves data_out alone
      run_txn(8'h02, 24'h000001, 8'h55, 8'd1, -1, -1, -1, r, st, l, dn, pv, to);
      check("prog_timeout", to, 1'b0);
      check("prog_rises", r, 40);
      check("prog_mosi", st, 64'h0200000155);
      check("prog_data_out", data_out, 8'hFF);
      check("prog_cs_low", l, 162);
      check("prog_done", dn, 1);

      // Program with a stray start (cmd=0x06) mid-transaction
      run_txn(8'h02, 24'h000001, 8'h55, 8'd1, -1, 12, -1, r, st, l, dn, pv, to);
      check("glitch_timeout", to, 1'b0);
      check("glitch_rises", r, 40);
      check("glitch_mosi", st, 64'h0200000155);
      check("glitch_cs_low", l, 162);
      check("glitch_done", dn, 1);

      // Reset at bit 20 of a read
      dbase = done_cnt;
      run_txn(8'h03, 24'h000001, 8'h00, 8'd1, -1, -1, 20, r, st, l, dn, pv, to);
      #1;
      check("abort_rises", r, 20);
      check("abort_cs_n", cs_n, 1'b1);
      check("abort_sck", sck, 1'b0);
      check("abort_data_out", data_out, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_no_done", done_cnt - dbase, 0);

      run_txn(8'h06, 24'h000000, 8'h00, 8'd0, -1, -1, -1, r, st, l, dn, pv, to);
      check("wren2_timeout", to, 1'b0);
      check("wren2_rises", r, 8);
      check("wren2_mosi", st, 64'h06);
      check("wren2_cs_low", l, 34);
      check("wren2_done", dn, 1);

      check("sck_low_when_cs_high", sck_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pmod_sf3_driver.md
# pmod_sf3_driver

SPI master for the Digilent Pmod SF3 (Micron N25Q serial NOR flash) in the input/memory subsystem. One `start` pulse runs one complete chip-select-framed transaction:
- an 8-bit opcode;
- an optional 24-bit address;
- an optional data phase of `data_len` bytes, transmitted or received according to the opcode.

`done` pulses when the transaction completes. Higher-level logic sequences WREN, program, read and status polling through this block.

## Interface
Parameters:
- CLK_DIV, default 2: `clk` cycles per SCK half-period; must be ≥1. SCK frequency is f_clk/(2·CLK_DIV).

Ports (one clock `clk`; reset `reset` is asynchronous and active-high):
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  async active-high. Forces IDLE, cs_n=1, sck=0, mosi=0, done=0, data_out=0.
- start  in  1  one-cycle request; accepted only in IDLE.
- cmd  in  8  opcode; latched on accept.
- addr  in  24  flash address; latched on accept.
- data_in  in  8  write byte; sampled at the start of each write-data byte.
- data_len  in  8  data-phase byte count; 0 = no data phase. Latched on accept.
- miso  in  1  serial data from the flash.
- mosi  out  1  serial data to the flash, MSB first.
- sck  out  1  SPI clock, mode 0 (idle low).
- cs_n  out  1  chip select, active low.
- data_out  out  8  last fully received byte; holds its value between reads.
- done  out  1  one-cycle pulse at the end of a transaction.

## Operation
- States: IDLE → CMD → [ADDR] → [DATA] → HOLD → IDLE.
- Opcode classes:
  - Address phase for 0x02, 0x03, 0x20, 0xD8.
  - Write-data phase for 0x02.
  - Read-data phase for 0x03, 0x05 (RDSR), 0x9F.
  - All other opcodes (e.g. 0x06 WREN, 0x04 WRDI) are opcode-only; `data_len` is ignored.
- Data phase is skipped when `data_len`=0.
- Write data: MSB first. With no new value on `data_in`, the same byte repeats for each of the `data_len` bytes.
- Read data:
  - mosi is driven 0.
  - Bits are shifted in MSB first.
  - data_out is updated when the 8th bit of each byte is sampled.
  - RDSR polling is done by the caller by repeating 0x05 transactions with data_len=1.
- `start` while not in IDLE is ignored; it is neither queued nor does it alter the transaction in progress.
- Reset mid-transaction aborts immediately: cs_n=1, sck=0, and no done pulse.

## Timing
- Accept edge (start=1 in IDLE):
  - cs_n←0, sck=0.
  - mosi←cmd[7].
  - Bit counter loaded; cmd, addr and data_len latched.
- Each bit occupies 2·CLK_DIV cycles:
  - CLK_DIV cycles with sck low (mosi stable), then CLK_DIV cycles with sck high.
  - miso is sampled on the edge that raises sck.
  - mosi advances to the next bit on the edge that lowers sck (mode 0).
- No gaps between bytes or phases; SCK runs continuously while cs_n is low.
- After the final bit's high phase:
  - sck←0.
  - HOLD lasts CLK_DIV cycles with cs_n low.
  - Then cs_n←1, done←1 for exactly one cycle, mosi←0, and the state returns to IDLE.
- start is accepted from the cycle after done.
- Total cs_n-low time = N_bits·2·CLK_DIV + CLK_DIV cycles, where N_bits = 8 + 24·has_addr + 8·data_bytes.
- At CLK_DIV=2:
  - WREN: 34 cycles.
  - Program or read with data_len=1: 40 bits, 162 cycles.
- Exactly N_bits SCK rising edges per transaction; sck is low whenever cs_n is high.

## Test plan
- WREN: cmd=0x06, data_len=1 →
  - 8 sck rises.
  - mosi samples 0000_0110.
  - cs_n low 34 cycles, then a single done pulse.
  - No data byte sent.
- Page program: cmd=0x02, addr=0x000001, data_in=0x55, data_len=1 →
  - 40 rises.
  - mosi stream 02 00 00 01 55.
  - data_out unchanged.
- Read: cmd=0x03, addr=0x000001, data_len=1, miso=1 →
  - mosi stream 03 00 00 01 then 00.
  - data_out=0xFF at done.
- RDSR: cmd=0x05, data_len=2, miso driven 0x03 then 0x00 →
  - 24 rises, no address.
  - data_out=0x03 after byte 1, 0x00 at done.
- start pulsed during a program transaction → ignored; stream and timing unchanged.
- reset asserted at bit 20 of a read →
  - cs_n=1, sck=0, data_out=0, no done.
  - The next WREN runs normally.
